// File: rtl/peak_detector_pkg.sv
// Shared defaults and helpers for the PPG peak detector slice.
package peak_detector_pkg;

    localparam int PD_WIDTH_DEF      = 10;
    localparam int PD_THRESH_DEF     = 50;
    localparam int PD_REF_PERIOD_DEF = 8;

    // The counter has to hold the refractory period itself, hence the +1.
    function automatic int refCntWidth(input int refPeriod);
        return (refPeriod < 1) ? 1 : $clog2(refPeriod + 1);
    endfunction

endpackage

// File: rtl/peak_refractory_timer.sv
// Refractory lockout counter: loads on a detection, counts down once per accepted sample.
module peak_refractory_timer
    import peak_detector_pkg::*;
#(
    parameter int PERIOD = PD_REF_PERIOD_DEF,
    parameter int CNT_W  = refCntWidth(PERIOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic strobe_i,
    output logic busy_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A load wins over a decrement so the detecting sample restarts the full lockout.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(PERIOD);
        end else if (strobe_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/peak_detector.sv
// Streaming local-maximum detector for the filtered PPG signal.
// Optional peak counter output enabled by defining PEAK_DETECTOR_COUNT_EN.
module peak_detector
    import peak_detector_pkg::*;
#(
    parameter int WIDTH      = PD_WIDTH_DEF,
    parameter int THRESH     = PD_THRESH_DEF,
    parameter int REF_PERIOD = PD_REF_PERIOD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] ppg_in,
    input  logic                    valid_in,
    output logic                    peak_detected
`ifdef PEAK_DETECTOR_COUNT_EN
    ,
    output logic [15:0]             peak_count
`endif
);

    localparam int REF_W = refCntWidth(REF_PERIOD);
    localparam logic signed [WIDTH-1:0] THRESH_S = THRESH[WIDTH-1:0];

    logic                    acc;
    logic                    confirm;
    logic                    refBusy;

    logic signed [WIDTH-1:0] s1_q, s1_d;
    logic signed [WIDTH-1:0] s2_q, s2_d;
    logic [1:0]              histCnt_q, histCnt_d;
    logic                    peak_q, peak_d;

    assign acc = en && valid_in;

    // s1 is the candidate: it must rise out of s2 and not be exceeded by the current sample.
    assign confirm = acc
                   && (histCnt_q == 2'd2)
                   && (s1_q > s2_q)
                   && (s1_q >= ppg_in)
                   && (s1_q > THRESH_S)
                   && !refBusy;

    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        histCnt_d = histCnt_q;
        peak_d    = confirm;
        if (acc) begin
            s2_d = s1_q;
            s1_d = ppg_in;
            if (histCnt_q != 2'd2) begin
                histCnt_d = histCnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            histCnt_q <= 2'd0;
            peak_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            histCnt_q <= histCnt_d;
            peak_q    <= peak_d;
        end
    end

    peak_refractory_timer #(
        .PERIOD (REF_PERIOD),
        .CNT_W  (REF_W)
    ) u_refTimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (confirm),
        .strobe_i (acc),
        .busy_o   (refBusy)
    );

    assign peak_detected = peak_q;

`ifdef PEAK_DETECTOR_COUNT_EN
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (confirm) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign peak_count = count_q;
`endif

endmodule

// File: tb/tb_peak_detector.sv
// Directed table-driven bench for peak_detector (THRESH=50, REF_PERIOD=8, sample every 2nd clock).
// Define PEAK_DETECTOR_COUNT_EN to also exercise the peak counter.
module tb_peak_detector;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic signed [9:0] ppg_in;
    logic              valid_in;
    logic              peak_detected;
`ifdef PEAK_DETECTOR_COUNT_EN
    logic [15:0]       peak_count;
`endif

    int checkCount;
    int failCount;

    typedef struct {
        string             tag;
        logic              doReset;
        logic              en;
        logic signed [9:0] sample;
        logic              expPeak;
    } vec_t;

    vec_t vecs[$];

    peak_detector #(
        .WIDTH      (10),
        .THRESH     (50),
        .REF_PERIOD (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .ppg_in        (ppg_in),
        .valid_in      (valid_in),
        .peak_detected (peak_detected)
`ifdef PEAK_DETECTOR_COUNT_EN
        ,
        .peak_count    (peak_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic addVec(input string tag, input logic doReset, input logic enV,
                          input logic signed [9:0] sample, input logic expPeak);
        vec_t v;
        v.tag     = tag;
        v.doReset = doReset;
        v.en      = enV;
        v.sample  = sample;
        v.expPeak = expPeak;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge; ends #1 after the second following edge.
    task automatic applyStimulus(input string tag, input logic enV,
                                 input logic signed [9:0] sample, input logic expPeak);
        en       = enV;
        ppg_in   = sample;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checkOutput({tag, " pulse"}, {15'd0, peak_detected}, {15'd0, expPeak});
        @(posedge clk); #1;
        checkOutput({tag, " clear"}, {15'd0, peak_detected}, 16'd0);
        en = 1'b1;
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        en         = 1'b1;
        ppg_in     = '0;
        valid_in   = 1'b0;

        addVec("basic0", 1, 1, 0, 0);
        addVec("basic20", 0, 1, 20, 0);
        addVec("basic60", 0, 1, 60, 0);
        addVec("basic80", 0, 1, 80, 0);
        addVec("basic70", 0, 1, 70, 1);
        addVec("basic40", 0, 1, 40, 0);

        addVec("sub10", 1, 1, 10, 0);
        addVec("sub40", 0, 1, 40, 0);
        addVec("sub45", 0, 1, 45, 0);
        addVec("sub30", 0, 1, 30, 0);
        addVec("sub50", 0, 1, 50, 0);
        addVec("sub20", 0, 1, 20, 0);

        addVec("ref0", 1, 1, 0, 0);
        addVec("ref100", 0, 1, 100, 0);
        addVec("ref90", 0, 1, 90, 1);
        addVec("ref95", 0, 1, 95, 0);
        addVec("ref200", 0, 1, 200, 0);
        addVec("ref150", 0, 1, 150, 0);

        // Second peak confirmed at k+9: just outside the lockout.
        addVec("k9_0", 1, 1, 0, 0);
        addVec("k9_100", 0, 1, 100, 0);
        addVec("k9_90", 0, 1, 90, 1);
        for (int i = 0; i < 7; i++) addVec("k9_fill", 0, 1, 10, 0);
        addVec("k9_200", 0, 1, 200, 0);
        addVec("k9_150", 0, 1, 150, 1);

        // Second peak at k+8: still the last locked-out sample.
        addVec("k8_0", 1, 1, 0, 0);
        addVec("k8_100", 0, 1, 100, 0);
        addVec("k8_90", 0, 1, 90, 1);
        for (int i = 0; i < 6; i++) addVec("k8_fill", 0, 1, 10, 0);
        addVec("k8_200", 0, 1, 200, 0);
        addVec("k8_150", 0, 1, 150, 0);

        addVec("plat_m512", 1, 1, -512, 0);
        addVec("plat60a", 0, 1, 60, 0);
        addVec("plat60b", 0, 1, 60, 1);
        addVec("plat60c", 0, 1, 60, 0);
        addVec("plat10", 0, 1, 10, 0);

        addVec("neg300", 1, 1, -300, 0);
        addVec("neg100", 0, 1, -100, 0);
        addVec("neg200", 0, 1, -200, 0);

        addVec("fs_lo", 1, 1, -512, 0);
        addVec("fs_hi", 0, 1, 511, 0);
        addVec("fs_lo2", 0, 1, -512, 1);

        addVec("en0_0", 1, 0, 0, 0);
        addVec("en0_20", 0, 0, 20, 0);
        addVec("en0_80", 0, 0, 80, 0);
        addVec("en0_70", 0, 0, 70, 0);
        addVec("en1_80", 0, 1, 80, 0);
        addVec("en1_70", 0, 1, 70, 0);

        // History must freeze while en is low.
        addVec("frz0", 1, 1, 0, 0);
        addVec("frz20", 0, 1, 20, 0);
        addVec("frz80", 0, 1, 80, 0);
        addVec("frz_off10", 0, 0, 10, 0);
        addVec("frz_off90", 0, 0, 90, 0);
        addVec("frz_off5", 0, 0, 5, 0);
        addVec("frz70", 0, 1, 70, 1);

        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("resetState", {15'd0, peak_detected}, 16'd0);

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            if (vecs[i].doReset) doReset();
            applyStimulus(vecs[i].tag, vecs[i].en, vecs[i].sample, vecs[i].expPeak);
        end

        // Async reset while the pulse is high and the lockout is loaded.
        doReset();
        applyStimulus("ar0", 1, 0, 0);
        applyStimulus("ar100", 1, 100, 0);
        en       = 1'b1;
        ppg_in   = 10'sd90;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checkOutput("ar90 pulse", {15'd0, peak_detected}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetClears", {15'd0, peak_detected}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus("post200", 1, 200, 0);
        applyStimulus("post100", 1, 100, 0);
        applyStimulus("post300", 1, 300, 0);
        applyStimulus("post250", 1, 250, 1);

`ifdef PEAK_DETECTOR_COUNT_EN
        doReset();
        checkOutput("countReset", peak_count, 16'd0);
        for (int p = 0; p < 3; p++) begin
            applyStimulus("cnt0", 1, 0, 0);
            applyStimulus("cnt100", 1, 100, 0);
            applyStimulus("cnt90", 1, 90, 1);
            for (int j = 0; j < 8; j++) applyStimulus("cntFill", 1, 10, 0);
        end
        checkOutput("countThree", peak_count, 16'd3);
        applyStimulus("cntOff0", 0, 0, 0);
        applyStimulus("cntOff100", 0, 100, 0);
        applyStimulus("cntOff90", 0, 90, 0);
        checkOutput("countHold", peak_count, 16'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
